// File: rtl/pipe_pkg.sv
// Shared types and constants for the parametrised pipeline stage register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

    // RV32 canonical NOP (addi x0, x0, 0), shown whenever a stage holds a bubble
    localparam logic [31:0] PIPE_NOP = 32'h00000013;

    // Occupancy of a stage: main register only, or main plus skid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } occ_e;

    // Bit offset of data field k inside a packed multi-field bus
    function automatic int field_off(input int k, input int data_width);
        return k * data_width;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between an upstream producer, the stage, and a downstream consumer.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry the valid-ready handshake on each side.
interface pipe_stage_skid_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DATA   = 2
);
    import pipe_pkg::*;

    logic                           in_valid;
    logic                           in_ready;
    logic [ADDR_WIDTH-1:0]          in_pc;
    logic [31:0]                    in_inst;
    logic [NUM_DATA*DATA_WIDTH-1:0] in_data;

    logic                           out_valid;
    logic                           out_ready;
    logic [ADDR_WIDTH-1:0]          out_pc;
    logic [31:0]                    out_inst;
    logic [NUM_DATA*DATA_WIDTH-1:0] out_data;

    // Environment side: produces upstream entries and consumes stage output
    modport master (
        output in_valid, in_pc, in_inst, in_data, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_data
    );

    // Stage side
    modport slave (
        input  in_valid, in_pc, in_inst, in_data, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_data
    );

endinterface

// File: rtl/pipe_stage_entry.sv
// Single valid+payload register with load and clear; clear wins over load.
// Latency: 1 cycle from load to q/vld.
// Backpressure: none; the owner decides when to load or clear.
module pipe_stage_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);

    logic         vld_d, vld_q;
    logic [W-1:0] dat_d, dat_q;

    // Next-state: clear drops valid but keeps the stale payload
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (clr) begin
            vld_d = 1'b0;
        end else if (load) begin
            vld_d = 1'b1;
            dat_d = d;
        end
    end

    // Entry register, payload resets to zero so idle outputs are deterministic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld = vld_q;
    assign q   = dat_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register (PC, inst, NUM_DATA fields) with 2-entry skid; optional PIPE_STAGE_PERF_EN counters.
// Latency: 1 cycle input to output, 1 entry/cycle throughput.
// Backpressure: in_ready is a flop (= skid empty); the skid absorbs the one entry accepted during a stall.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int          ADDR_WIDTH = 15,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_DATA   = 2,
    parameter logic [31:0] NOP_INST   = PIPE_NOP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_bubble_cnt,
`endif
    pipe_stage_skid_if.slave      bus
);

    localparam int DW = NUM_DATA * DATA_WIDTH;
    localparam int PW = ADDR_WIDTH + 32 + DW;

    occ_e          state_d, state_q;
    logic          in_rdy_d, in_rdy_q;
    logic          main_load, main_clr, skid_load, skid_clr;
    logic          main_vld, skid_vld;
    logic [PW-1:0] in_pay, main_in, main_pay, skid_pay;
    logic          in_xfer, out_xfer;

    assign in_pay   = {bus.in_pc, bus.in_inst, bus.in_data};
    assign in_xfer  = bus.in_valid && in_rdy_q;
    assign out_xfer = main_vld && bus.out_ready;
    // Main refills from the skid whenever the skid holds the older entry
    assign main_in  = skid_vld ? skid_pay : in_pay;

    // Occupancy FSM: decides entry loads/clears and the next in_ready
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_d   = FULL;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (out_xfer) begin
                        main_clr = 1'b1;
                        state_d  = EMPTY;
                    end else if (in_xfer) begin
                        skid_load = 1'b1;
                        state_d   = SKID;
                    end
                end
                SKID: begin
                    if (out_xfer) begin
                        main_load = 1'b1;
                        skid_clr  = 1'b1;
                        state_d   = FULL;
                    end
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                    state_d  = EMPTY;
                end
            endcase
        end
        in_rdy_d = (state_d != SKID);
    end

    // State and registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            in_rdy_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_rdy_q <= in_rdy_d;
        end
    end

    pipe_stage_entry #(.W(PW)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .clr  (main_clr),
        .d    (main_in),
        .vld  (main_vld),
        .q    (main_pay)
    );

    pipe_stage_entry #(.W(PW)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .clr  (skid_clr),
        .d    (in_pay),
        .vld  (skid_vld),
        .q    (skid_pay)
    );

    assign bus.in_ready  = in_rdy_q;
    assign bus.out_valid = main_vld;
    assign bus.out_pc    = main_pay[PW-1 -: ADDR_WIDTH];
    assign bus.out_inst  = main_vld ? main_pay[DW +: 32] : NOP_INST;
    assign bus.out_data  = main_pay[DW-1:0];

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_d, stall_q, bubble_d, bubble_q;

    // Stall/bubble counters, free-running wrap, untouched by flush
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (main_vld && !bus.out_ready) stall_d  = stall_q + 32'd1;
        if (!main_vld && bus.out_ready) bubble_d = bubble_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign perf_stall_cnt  = stall_q;
    assign perf_bubble_cnt = bubble_q;
`endif

endmodule
